// File: rtl/mux_rr_4.sv
// mux_rr_4: four-input round-robin arbitrated multiplexer.
// Merges four valid/ready streams into one registered output stream and
// tags every output beat with the 2-bit index of the source that produced it.
module mux_rr_4 #(
    parameter int unsigned BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic                 a_valid,
    input  logic                 b_valid,
    input  logic                 c_valid,
    input  logic                 d_valid,
    output logic                 a_ready,
    output logic                 b_ready,
    output logic                 c_ready,
    output logic                 d_ready,
    output logic [BUS_WIDTH-1:0] y,
    output logic [1:0]           y_sel,
    output logic                 y_valid,
    input  logic                 y_ready
);

    logic [BUS_WIDTH-1:0] y_q, y_d;
    logic [1:0]           sel_q, sel_d;
    logic                 yv_q, yv_d;
    logic [1:0]           ptr_q, ptr_d;

    logic [3:0]           valid_vec;
    logic [3:0]           grant;
    logic [3:0]           ready_vec;
    logic [1:0]           gidx;
    logic [1:0]           idx;
    logic                 found;
    logic                 load;
    logic                 push;
    logic [BUS_WIDTH-1:0] gdata;

    assign valid_vec = {d_valid, c_valid, b_valid, a_valid};

    // Grant the first valid source scanning upward from ptr, wrapping mod 4.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!found && valid_vec[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    // Output register can take a beat when empty or being drained this cycle.
    always_comb begin
        load      = !yv_q || y_ready;
        ready_vec = grant & {4{load & rst_n}};
        push      = |ready_vec;
    end

    assign a_ready = ready_vec[0];
    assign b_ready = ready_vec[1];
    assign c_ready = ready_vec[2];
    assign d_ready = ready_vec[3];

    // Select the granted source's data.
    always_comb begin
        gdata = '0;
        case (gidx)
            2'd0:    gdata = a;
            2'd1:    gdata = b;
            2'd2:    gdata = c;
            default: gdata = d;
        endcase
    end

    // Next state: push loads a new beat (even while popping), pop alone empties.
    always_comb begin
        y_d   = y_q;
        sel_d = sel_q;
        yv_d  = yv_q;
        ptr_d = ptr_q;
        if (push) begin
            y_d   = gdata;
            sel_d = gidx;
            yv_d  = 1'b1;
            ptr_d = gidx + 2'd1;
        end else if (yv_q && y_ready) begin
            yv_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= '0;
            yv_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
            yv_q  <= yv_d;
            ptr_q <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_sel   = sel_q;
    assign y_valid = yv_q;

endmodule

// File: tb/tb_mux_rr_4.sv
// tb_mux_rr_4: directed and randomized checks of mux_rr_4 against a
// behavioural round-robin reference model.
module tb_mux_rr_4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sd [4];
    logic       sv [4];
    logic       y_ready;

    logic       a_ready, b_ready, c_ready, d_ready;
    logic [7:0] y;
    logic [1:0] y_sel;
    logic       y_valid;
    logic [3:0] rdy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_ptr;
    logic [7:0] m_y;
    logic [1:0] m_sel;
    logic       m_yv;
    logic [3:0] acc;

    assign rdy = {d_ready, c_ready, b_ready, a_ready};

    mux_rr_4 #(.BUS_WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (sd[0]),
        .b       (sd[1]),
        .c       (sd[2]),
        .d       (sd[3]),
        .a_valid (sv[0]),
        .b_valid (sv[1]),
        .c_valid (sv[2]),
        .d_valid (sv[3]),
        .a_ready (a_ready),
        .b_ready (b_ready),
        .c_ready (c_ready),
        .d_ready (d_ready),
        .y       (y),
        .y_sel   (y_sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int exp_grant();
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (sv[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int g;
        r = 4'b0000;
        g = exp_grant();
        if (rst_n && (!m_yv || y_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Advance one clock edge and update the reference model; ends 1 ns after the edge.
    task automatic step();
        int   g;
        logic ld;
        g  = exp_grant();
        ld = !m_yv || y_ready;
        @(posedge clk);
        acc = 4'b0000;
        if (!rst_n) begin
            m_y = 8'h00; m_sel = 2'd0; m_yv = 1'b0; m_ptr = 0;
        end else if (ld && g >= 0) begin
            m_y    = sd[g];
            m_sel  = 2'(g);
            m_yv   = 1'b1;
            m_ptr  = (g + 1) % 4;
            acc[g] = 1'b1;
        end else if (m_yv && y_ready) begin
            m_yv = 1'b0;
        end
        #1;
    endtask

    task automatic set_src(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        sv[0] = v[0]; sv[1] = v[1]; sv[2] = v[2]; sv[3] = v[3];
        sd[0] = d0;   sd[1] = d1;   sd[2] = d2;   sd[3] = d3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_src(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        y_ready = 1'b1;
        rst_n   = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (rdy !== 4'b0000) begin
                errors++; $display("FAIL reset_ready: got %b expected 0000", rdy);
            end
            step();
            checks++;
            if (y_valid !== 1'b0 || y !== 8'h00 || y_sel !== 2'd0) begin
                errors++;
                $display("FAIL reset_state: got yv=%b y=%h sel=%0d expected yv=0 y=00 sel=0",
                         y_valid, y, y_sel);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'b0001) begin
            errors++; $display("FAIL reset_first_ready: got %b expected 0001", rdy);
        end
        step();
        checks++;
        if (y_valid !== 1'b1 || y !== 8'h11 || y_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_beat: got yv=%b y=%h sel=%0d expected yv=1 y=11 sel=0",
                     y_valid, y, y_sel);
        end
        // ptr must now be 1: b is next in line
        checks++;
        if (rdy !== 4'b0010) begin
            errors++; $display("FAIL reset_ptr_after: got %b expected 0010", rdy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ed [5];
        logic [1:0] es [5];
        ed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        set_src(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        y_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (y_valid !== 1'b1 || y !== ed[n] || y_sel !== es[n]) begin
                errors++;
                $display("FAIL round_robin[%0d]: got yv=%b y=%h sel=%0d expected yv=1 y=%h sel=%0d",
                         n, y_valid, y, y_sel, ed[n], es[n]);
            end
        end
    endtask

    task automatic test_wrap_skip();
        logic [1:0] es [4];
        logic [7:0] ed [4];
        es = '{2'd1, 2'd3, 2'd1, 2'd3};
        ed = '{8'hB0, 8'hD0, 8'hB0, 8'hD0};
        set_src(4'b1010, 8'h00, 8'hB0, 8'h00, 8'hD0);
        y_ready = 1'b1;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++;
            if (rdy !== (4'b0001 << es[n])) begin
                errors++;
                $display("FAIL wrap_ready[%0d]: got %b expected %b", n, rdy, 4'b0001 << es[n]);
            end
            step();
            checks++;
            if (y_valid !== 1'b1 || y !== ed[n] || y_sel !== es[n]) begin
                errors++;
                $display("FAIL wrap_beat[%0d]: got y=%h sel=%0d expected y=%h sel=%0d",
                         n, y, y_sel, ed[n], es[n]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_src(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
        y_ready = 1'b1;
        do_reset();
        step();
        checks++;
        if (y !== 8'h5A || y_sel !== 2'd2 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_load: got y=%h sel=%0d yv=%b expected y=5a sel=2 yv=1", y, y_sel, y_valid);
        end
        set_src(4'b0001, 8'hA1, 8'h00, 8'h00, 8'h00);
        y_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0) begin
                errors++; $display("FAIL bp_a_ready[%0d]: got %b expected 0", n, a_ready);
            end
            step();
            checks++;
            if (y !== 8'h5A || y_sel !== 2'd2 || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got y=%h sel=%0d yv=%b expected y=5a sel=2 yv=1",
                         n, y, y_sel, y_valid);
            end
        end
        y_ready = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 1", a_ready);
        end
        step();
        checks++;
        if (y !== 8'hA1 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_beat: got y=%h sel=%0d yv=%b expected y=a1 sel=0 yv=1",
                     y, y_sel, y_valid);
        end
    endtask

    task automatic test_back_to_back();
        // output holds a beat (A1 from the previous task); pop and push together
        set_src(4'b0010, 8'h00, 8'hB7, 8'h00, 8'h00);
        y_ready = 1'b1;
        #1;
        checks++;
        if (b_ready !== 1'b1 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got b_ready=%b yv=%b expected 1 1", b_ready, y_valid);
        end
        step();
        checks++;
        if (y !== 8'hB7 || y_sel !== 2'd1 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_beat: got y=%h sel=%0d yv=%b expected y=b7 sel=1 yv=1", y, y_sel, y_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        // output holds B7 with ptr=2; stall, then reset
        set_src(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        y_ready = 1'b0;
        step();
        set_src(4'b1111, 8'h71, 8'h72, 8'h73, 8'h74);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 4'b0000) begin
            errors++; $display("FAIL rst_stall_ready: got %b expected 0000", rdy);
        end
        step();
        checks++;
        if (y_valid !== 1'b0 || y !== 8'h00 || y_sel !== 2'd0) begin
            errors++;
            $display("FAIL rst_stall_state: got yv=%b y=%h sel=%0d expected yv=0 y=00 sel=0",
                     y_valid, y, y_sel);
        end
        rst_n   = 1'b1;
        y_ready = 1'b1;
        #1;
        checks++;
        if (rdy !== 4'b0001) begin
            errors++; $display("FAIL rst_stall_ptr: got %b expected 0001", rdy);
        end
        step();
        checks++;
        if (y !== 8'h71 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_stall_next: got y=%h sel=%0d yv=%b expected y=71 sel=0 yv=1",
                     y, y_sel, y_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(59) != 0);
            y_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!(sv[i] && !acc[i])) begin
                    sv[i] = 1'($urandom_range(1));
                    sd[i] = 8'($urandom);
                end
            end
            #1;
            er = exp_ready();
            checks++;
            if (rdy !== er) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, rdy, er);
            end
            step();
            checks++;
            if (y_valid !== m_yv || y !== m_y || y_sel !== m_sel) begin
                errors++;
                $display("FAIL rand_out[%0d]: got yv=%b y=%h sel=%0d expected yv=%b y=%h sel=%0d",
                         n, y_valid, y, y_sel, m_yv, m_y, m_sel);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; y_ready = 1'b0;
        set_src(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        m_ptr = 0; m_y = 8'h00; m_sel = 2'd0; m_yv = 1'b0; acc = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_4.md
# mux_rr_4

Four-input, round-robin arbitrated multiplexer that merges four valid/ready streams of `BUS_WIDTH`-bit beats into one registered output stream. It is the gathering counterpart of the team's 1-to-4 demultiplexer. Each output beat carries a 2-bit source tag, `y_sel`, with the same encoding as the demux select (a=0, b=1, c=2, d=3), so the merged stream can later be split again. It sits between four producers and one shared consumer.

## Interface
- `BUS_WIDTH`, default 8: width of every data bus.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low; sampled on `clk`.
- `a`, `b`, `c`, `d` input `BUS_WIDTH`: source data for index 0, 1, 2, 3.
- `a_valid`, `b_valid`, `c_valid`, `d_valid` input 1: the source holds a beat.
- `a_ready`, `b_ready`, `c_ready`, `d_ready` output 1: the beat is accepted this cycle.
- `y` output `BUS_WIDTH`: registered output data.
- `y_sel` output 2: index of the source that produced `y`.
- `y_valid` output 1: the output register holds a beat.
- `y_ready` input 1: the consumer accepts `y` this cycle.

## Operation
- **State:**
  - output register holding `y`, `y_sel` and `y_valid`;
  - 2-bit priority pointer `ptr`, which names the highest-priority source.
- **Reset** (`rst_n`=0 at a rising edge):
  - `y`=0, `y_sel`=0, `y_valid`=0, `ptr`=0.
  - All `*_ready` outputs are 0 during the reset cycle.
- **Load enable:** `load = !y_valid || y_ready`. The output register is free, or is being emptied this cycle.
- **Grant:**
  - Combinational, one-hot.
  - The first valid source found scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) is granted.
  - With no valid source there is no grant.
- **Source ready:** `x_ready = grant[x] && load && rst_n`. At most one ready is high per cycle.
  - A ready may depend on that source's valid.
  - A valid must never depend on its own ready.
- **On an input handshake from source i:**
  - `y` ← source data, `y_sel` ← i, `y_valid` ← 1.
  - `ptr` ← (i+1) mod 4, with natural 2-bit wrap (3 → 0).
- **On output handshake only** (`y_valid && y_ready`, no input handshake): `y_valid` ← 0.
  - `y` and `y_sel` keep their last values.
  - `ptr` is unchanged.
- **Simultaneous output pop and input push:** the new beat is loaded, and `y_valid` stays 1 with no bubble.
- **Stall** (`y_valid && !y_ready`):
  - No ready is asserted.
  - `y`, `y_sel` and `ptr` hold.
  - The grant may change as source valids change; nothing is consumed.
- **Fairness:** a source holding valid is granted within at most 4 load opportunities. `ptr` moves only on an accepted beat.
- **Reset mid-operation:** any beat held in the output register is discarded. The register returns to its reset state on that edge, with no partial update.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `y` with `y_valid`=1 after edge N.
- Throughput is 1 beat per cycle while `y_ready` stays 1.
- `y`, `y_sel` and `y_valid` come straight from flops, with no combinational path from inputs.
- Combinational paths exist from `*_valid` and `y_ready` to `*_ready`.
- While `y_valid`=1 and `y_ready`=0, `y` and `y_sel` are stable until the handshake completes.
- Sources must hold data stable while valid=1 and ready=0.

## Test plan
- **Reset:**
  - Stimulus: drive `rst_n`=0 for 2 cycles with all valids=1.
  - Required: `y_valid`=0, `y`=0, `y_sel`=0, and every `*_ready`=0.
  - After release with `y_ready`=1: the first beat comes from a, then `ptr`=1.
- **Round-robin:**
  - Stimulus: all four valid with data a=0x11, b=0x22, c=0x33, d=0x44; `y_ready` held at 1.
  - Required output (`y`/`y_sel`): 0x11/0, 0x22/1, 0x33/2, 0x44/3, 0x11/0. One beat per cycle, the first one cycle after release.
- **Pointer wrap and skip:**
  - Stimulus: only d (0xD0) and b (0xB0) valid, starting from `ptr`=0.
  - Required order: b, d, b, d.
  - After d is accepted, `ptr`=0 (wrap from 3).
- **Backpressure:**
  - Stimulus: c=0x5A is accepted, then `y_ready`=0 for 3 cycles while a is valid.
  - Required during the stall: `y`=0x5A, `y_sel`=2, `y_valid`=1, `a_ready`=0.
  - Required when `y_ready` returns to 1: a is loaded in the same cycle.
- **Pop and push in the same cycle:**
  - Stimulus: `y_valid`=1 and `y_ready`=1 while b is valid.
  - Required: `b_ready`=1, and the next cycle shows b's data with `y_valid` still 1 (no bubble).
- **Reset mid-stall:**
  - Stimulus: `y_valid`=1 with `y_ready`=0, then `rst_n`=0 for 1 cycle.
  - Required: `y_valid`=0 and `ptr`=0 on the next edge; the held beat is never delivered.
